// File: rtl/dmem_stall_responder_pkg.sv
// Shared definitions for the multi-cycle data-memory responder.
package dmem_stall_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Latency counter sized for the largest legal latency (15).
    localparam int unsigned CNT_W = $clog2(16);

    // Bit positions in the captured error-cause vector.
    localparam int unsigned ERR_MISALIGN = 0;
    localparam int unsigned ERR_RDWR     = 1;
    localparam int unsigned ERR_W        = 2;

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous write, asynchronous read, contents never reset.
module dmem_array #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  ridx,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/dmem_stall_responder.sv
// MEM-stage data memory: accepts one access, stalls, and pulses done after LATENCY cycles.
module dmem_stall_responder
    import dmem_stall_responder_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd,
    input  logic              wr,
    output logic [DATA_W-1:0] data_out,
    output logic              done,
    output logic              stall,
    output logic              err_data
);

    localparam int unsigned IDX_W    = $clog2(DEPTH);
    // WAIT lasts LATENCY-1 cycles, so the counter starts at LATENCY-2.
    localparam int unsigned CNT_LOAD = (LATENCY > 1) ? LATENCY - 2 : 0;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [IDX_W-1:0]   cap_idx, cap_idx_next;
    logic [DATA_W-1:0]  cap_data, cap_data_next;
    logic               cap_wr, cap_wr_next;
    logic               cap_err, cap_err_next;
    logic               done_next, err_next;
    logic [DATA_W-1:0]  data_out_next;

    logic               req;
    logic [ERR_W-1:0]   live_cause;
    logic [IDX_W-1:0]   live_idx;
    logic [IDX_W-1:0]   sel_idx;
    logic [DATA_W-1:0]  sel_data;
    logic               sel_wr, sel_err;
    logic               finish;
    logic               we;
    logic [DATA_W-1:0]  rdata;

    assign req   = rd | wr;
    assign stall = req & ~done;

    assign live_cause[ERR_MISALIGN] = addr[0];
    assign live_cause[ERR_RDWR]     = rd & wr;
    assign live_idx                 = IDX_W'(addr[ADDR_W-1:1]);

    // Live request when finishing straight from IDLE, captured request otherwise.
    assign sel_idx  = (state == IDLE) ? live_idx    : cap_idx;
    assign sel_data = (state == IDLE) ? data_in     : cap_data;
    assign sel_wr   = (state == IDLE) ? wr          : cap_wr;
    assign sel_err  = (state == IDLE) ? |live_cause : cap_err;

    assign we = finish & sel_wr & ~sel_err;

    dmem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (we),
        .widx  (sel_idx),
        .wdata (sel_data),
        .ridx  (sel_idx),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            cap_idx  <= '0;
            cap_data <= '0;
            cap_wr   <= 1'b0;
            cap_err  <= 1'b0;
            done     <= 1'b0;
            err_data <= 1'b0;
            data_out <= '0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            cap_idx  <= cap_idx_next;
            cap_data <= cap_data_next;
            cap_wr   <= cap_wr_next;
            cap_err  <= cap_err_next;
            done     <= done_next;
            err_data <= err_next;
            data_out <= data_out_next;
        end
    end

    // Next state, capture, and response values; finish marks the edge done rises on.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        cap_idx_next  = cap_idx;
        cap_data_next = cap_data;
        cap_wr_next   = cap_wr;
        cap_err_next  = cap_err;
        done_next     = 1'b0;
        err_next      = err_data;
        data_out_next = data_out;
        finish        = 1'b0;

        case (state)
            IDLE: begin
                if (req) begin
                    cap_idx_next  = live_idx;
                    cap_data_next = data_in;
                    cap_wr_next   = wr;
                    cap_err_next  = |live_cause;
                    cnt_next      = CNT_W'(CNT_LOAD);
                    if (LATENCY <= 1) begin
                        state_next = RESP;
                        finish     = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_next = IDLE;
                end else if (cnt == '0) begin
                    state_next = RESP;
                    finish     = 1'b1;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (finish) begin
            done_next     = 1'b1;
            err_next      = sel_err;
            data_out_next = (sel_err || sel_wr) ? '0 : rdata;
        end
    end

endmodule

// File: tb/tb_dmem_stall_responder.sv
// Scoreboard bench for dmem_stall_responder: unit 0 at LATENCY=2, unit 1 at LATENCY=1.
module tb_dmem_stall_responder;

    localparam int unsigned AW    = 16;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned NU    = 2;

    typedef struct {
        logic          err;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [AW-1:0] addr     [NU];
    logic [DW-1:0] data_in  [NU];
    logic [DW-1:0] data_out [NU];
    logic          rd       [NU];
    logic          wr       [NU];
    logic          done     [NU];
    logic          stall    [NU];
    logic          err_data [NU];

    exp_t          sbq [NU][$];
    logic [DW-1:0] model [NU][DEPTH];
    exp_t          last_exp [NU];

    int checks;
    int passes;

    dmem_stall_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .LATENCY(2)) u_dut2 (
        .clk(clk), .rst(rst), .addr(addr[0]), .data_in(data_in[0]), .rd(rd[0]), .wr(wr[0]),
        .data_out(data_out[0]), .done(done[0]), .stall(stall[0]), .err_data(err_data[0])
    );

    dmem_stall_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .addr(addr[1]), .data_in(data_in[1]), .rd(rd[1]), .wr(wr[1]),
        .data_out(data_out[1]), .done(done[1]), .stall(stall[1]), .err_data(err_data[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int u, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s unit%0d: got %h expected %h at %0t", name, u, act, expv, $time);
    endtask

    function automatic int idx_of(input logic [AW-1:0] a);
        return int'(a >> 1) % int'(DEPTH);
    endfunction

    // Monitor: pops the scoreboard on every done pulse, otherwise checks the held outputs.
    always @(negedge clk) begin
        if (rst) begin
            for (int u = 0; u < NU; u++) begin
                last_exp[u].err  = 1'b0;
                last_exp[u].data = '0;
            end
        end else begin
            for (int u = 0; u < NU; u++) begin
                if (done[u]) begin
                    if (sbq[u].size() == 0) begin
                        check("unexpected_done", u, 32'd1, 32'd0);
                    end else begin
                        last_exp[u] = sbq[u].pop_front();
                        check("done_data", u, 32'(data_out[u]), 32'(last_exp[u].data));
                        check("done_err", u, 32'(err_data[u]), 32'(last_exp[u].err));
                    end
                end else begin
                    check("hold_data", u, 32'(data_out[u]), 32'(last_exp[u].data));
                    check("hold_err", u, 32'(err_data[u]), 32'(last_exp[u].err));
                end
            end
        end
    end

    // Issue one access in an IDLE cycle, check stall and latency, then release the request.
    task automatic issue(input int u, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        int   k;
        int   lat;
        lat = (u == 0) ? 2 : 1;
        if (a[0] || (r && w)) begin
            e.err = 1'b1; e.data = '0;
        end else if (w) begin
            e.err = 1'b0; e.data = '0;
            model[u][idx_of(a)] = d;
        end else begin
            e.err = 1'b0; e.data = model[u][idx_of(a)];
        end
        sbq[u].push_back(e);
        rd[u] = r; wr[u] = w; addr[u] = a; data_in[u] = d;
        #1;
        check("stall_req", u, 32'(stall[u]), 32'd1);
        k = 0;
        while (!done[u] && k < lat + 4) begin
            @(posedge clk); #1;
            k++;
            if (!done[u]) check("stall_wait", u, 32'(stall[u]), 32'd1);
        end
        check("latency", u, done[u] ? 32'(k) : 32'd99, 32'(lat));
        if (done[u]) check("stall_done", u, 32'(stall[u]), 32'd0);
        rd[u] = 1'b0; wr[u] = 1'b0;
        @(posedge clk); #1;
        check("done_pulse", u, 32'(done[u]), 32'd0);
    endtask

    // Write dropped during WAIT: no done, back in IDLE on the next edge.
    task automatic cancel_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr[0] = 1'b1; addr[0] = a; data_in[0] = d;
        @(posedge clk); #1;
        wr[0] = 1'b0;
        #1;
        check("cancel_stall", 0, 32'(stall[0]), 32'd0);
        @(posedge clk); #1;
        check("cancel_done", 0, 32'(done[0]), 32'd0);
    endtask

    // Write interrupted by reset in its WAIT cycle.
    task automatic reset_mid(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr[0] = 1'b1; addr[0] = a; data_in[0] = d;
        @(posedge clk); #1;
        rst = 1'b1; wr[0] = 1'b0;
        #1;
        check("rstmid_done", 0, 32'(done[0]), 32'd0);
        check("rstmid_err", 0, 32'(err_data[0]), 32'd0);
        check("rstmid_data", 0, 32'(data_out[0]), 32'd0);
        check("rstmid_stall", 0, 32'(stall[0]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        logic          r, w;
        checks = 0;
        passes = 0;
        rst = 1'b1;
        for (int u = 0; u < NU; u++) begin
            rd[u] = 1'b0; wr[u] = 1'b0; addr[u] = '0; data_in[u] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int u = 0; u < NU; u++) begin
            check("reset_done", u, 32'(done[u]), 32'd0);
            check("reset_err", u, 32'(err_data[u]), 32'd0);
            check("reset_data", u, 32'(data_out[u]), 32'd0);
            check("reset_stall", u, 32'(stall[u]), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        for (int u = 0; u < NU; u++) begin
            issue(u, 1'b0, 1'b1, 16'h0010, 16'hBEEF);
            issue(u, 1'b1, 1'b0, 16'h0010, 16'h0000);
            repeat (3) @(posedge clk);
            #1;
            issue(u, 1'b1, 1'b0, 16'h0011, 16'h0000);
            issue(u, 1'b1, 1'b0, 16'h0010, 16'h0000);
            issue(u, 1'b1, 1'b1, 16'h0010, 16'h1234);
            issue(u, 1'b1, 1'b0, 16'h0010, 16'h0000);
            issue(u, 1'b0, 1'b1, 16'h0800, 16'hA5A5);
            issue(u, 1'b1, 1'b0, 16'h0000, 16'h0000);
        end

        issue(0, 1'b0, 1'b1, 16'h0020, 16'h7777);
        cancel_write(16'h0020, 16'h5555);
        issue(0, 1'b1, 1'b0, 16'h0020, 16'h0000);
        issue(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        reset_mid(16'h0020, 16'h5555);
        issue(0, 1'b1, 1'b0, 16'h0020, 16'h0000);
        issue(1, 1'b1, 1'b0, 16'h0010, 16'h0000);

        for (int u = 0; u < NU; u++) begin
            for (int i = 0; i < 8; i++) begin
                a = AW'(i * 2);
                issue(u, 1'b0, 1'b1, a, DW'($urandom));
            end
            for (int n = 0; n < 40; n++) begin
                a = '0;
                a[15:11] = 5'($urandom);
                a[3:1]   = 3'($urandom);
                a[0]     = ($urandom_range(0, 3) == 0);
                r = 1'($urandom_range(0, 1));
                w = ~r;
                if ($urandom_range(0, 7) == 0) begin
                    r = 1'b1; w = 1'b1;
                end
                issue(u, r, w, a, DW'($urandom));
            end
        end

        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < NU; u++) begin
            check("scoreboard_drain", u, 32'(sbq[u].size()), 32'd0);
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
